// File: rtl/alu_result_trace_fifo.sv
// ALU result trace FIFO.
// Captures qualifying ALU results, each tagged with the PC that produced it,
// into a register-based FIFO. The FIFO drains over a valid/ready handshake to
// a host or debug link. This gives visibility of execution on hardware.
//
// Occupancy is tracked by an explicit counter. full and empty are registered
// from the next-state count, so they never depend on pointer equality. The
// head entry is a combinational read of mem[rd_ptr]. out_valid comes only
// from a register, so there is no combinational path from out_ready.
module alu_result_trace_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int FILTER_REPEATS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] pc_value,
  input  logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic [15:0]           overflow_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Each entry is stored as {pc, result}.
  logic [2*DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  logic                  full_q;
  logic                  empty_q;
  logic                  overflow_q;
  logic [15:0]           overflow_count_q;
  logic                  have_last;
  logic [DATA_WIDTH-1:0] last_result;

  logic flush;
  logic qualify;
  logic pop;
  logic push;
  logic drop;

  // Handshake and qualification decode, plus next-state occupancy.
  always_comb begin
    flush      = reset | clear;
    qualify    = capture_en &
                 ((FILTER_REPEATS == 0) | ~have_last | (alu_result != last_result));
    pop        = ~empty_q & out_ready;
    push       = qualify & (~full_q | pop);
    drop       = qualify & full_q & ~pop;
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_q + CW'(1);
    end else if (pop && !push) begin
      count_next = count_q - CW'(1);
    end
  end

  // Entry storage. It is not reset, and a push in a flush cycle is discarded.
  always_ff @(posedge clk) begin
    if (!flush && push) begin
      mem[wr_ptr] <= {pc_value, alu_result};
    end
  end

  // Pointers, filter history, overflow status and registered occupancy flags.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      have_last        <= 1'b0;
      last_result      <= '0;
      overflow_q       <= 1'b0;
      overflow_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      // The filter history advances even when the sample is dropped.
      if (qualify) begin
        last_result <= alu_result;
        have_last   <= 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (overflow_count_q != 16'hFFFF) begin
          overflow_count_q <= overflow_count_q + 16'd1;
        end
      end
    end
    count_q <= count_next;
    full_q  <= (count_next == DEPTH_C);
    empty_q <= (count_next == '0);
  end

  assign out_valid      = ~empty_q;
  assign out_result     = mem[rd_ptr][DATA_WIDTH-1:0];
  assign out_pc         = mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
  assign count          = count_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign overflow       = overflow_q;
  assign overflow_count = overflow_count_q;

endmodule
